// File: rtl/adder_arbiter_pkg.sv
// Shared defaults for the adder arbiter. The overflow output stays off
// unless ADDER_ARB_OVERFLOW_EN is defined at build time.
package adder_arbiter_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TAG_W   = 6;

    // Source-index width: $clog2(n), but never below one bit.
    function automatic int calc_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Ripple-carry adder shared by all arbiter requesters.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping. Outputs are zero when en_i is low.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters with a single
// registered, backpressured result stage. Define ADDER_ARB_OVERFLOW_EN to add out_ovf.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int SRC_W   = calc_src_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_sum,
    output logic                      out_cout,
    output logic [TAG_W-1:0]          out_tag,
`ifdef ADDER_ARB_OVERFLOW_EN
    output logic                      out_ovf,
`endif
    output logic [SRC_W-1:0]          out_src
);

    logic              valid_q;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic [TAG_W-1:0]  tag_q;
    logic [SRC_W-1:0]  src_q;
    logic [SRC_W-1:0]  ptr_q, ptr_d;

    logic              stage_free, arb_en, accept;
    logic [SRC_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] a_mux, b_mux, sum;
    logic              cin_mux, cout;
    logic [TAG_W-1:0]  tag_mux;

    assign stage_free = !valid_q || out_ready;
    assign arb_en     = stage_free && !flush && !rst;

    rr_arbiter #(.N(NUM_REQ), .IW(SRC_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (req_ready),
        .idx_o (gnt_idx)
    );

    assign accept = |req_ready;

    // AND-OR mux; req_ready is one-hot or zero.
    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        cin_mux = 1'b0;
        tag_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                a_mux   |= req_a[i*DATA_W +: DATA_W];
                b_mux   |= req_b[i*DATA_W +: DATA_W];
                cin_mux |= req_cin[i];
                tag_mux |= req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    adder #(.WIDTH(DATA_W)) u_adder (
        .a_i    (a_mux),
        .b_i    (b_mux),
        .cin_i  (cin_mux),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + SRC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            tag_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sum_q   <= sum;
            cout_q  <= cout;
            tag_q   <= tag_mux;
            src_q   <= gnt_idx;
            ptr_q   <= ptr_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ADDER_ARB_OVERFLOW_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (!flush && accept)
            ovf_q <= (a_mux[DATA_W-1] == b_mux[DATA_W-1]) &&
                     (sum[DATA_W-1] != a_mux[DATA_W-1]);
    end
    assign out_ovf = ovf_q;
`endif

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_tag   = tag_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed plus randomized checks of adder_arbiter against an arithmetic
// reference model (round-robin pick, one-deep result slot).
module tb_adder_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TW = 6;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst, flush, out_ready;
    logic [NR-1:0]     req_valid, req_ready, req_cin;
    logic [NR*DW-1:0]  req_a, req_b;
    logic [NR*TW-1:0]  req_tag;
    logic              out_valid, out_cout;
    logic [DW-1:0]     out_sum;
    logic [TW-1:0]     out_tag;
    logic [SW-1:0]     out_src;
`ifdef ADDER_ARB_OVERFLOW_EN
    logic              out_ovf;
`endif

    always #5 clk = ~clk;

    adder_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_tag(out_tag),
`ifdef ADDER_ARB_OVERFLOW_EN
        .out_ovf(out_ovf),
`endif
        .out_src(out_src)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int        m_ptr = 0;
    bit        m_v = 0;
    bit [31:0] m_sum = 0;
    bit        m_cout = 0;
    bit [5:0]  m_tag = 0;
    int        m_src = 0;
    bit        m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit [31:0] a, input bit [31:0] b,
                           input bit cin, input bit [5:0] tag);
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
        req_cin[i]          = cin;
        req_tag[i*TW +: TW] = tag;
    endtask

    // One clock: check req_ready mid-cycle, advance model at the edge,
    // then check the registered outputs just after it.
    task automatic tick(input string name);
        int        g;
        bit        acc;
        bit [32:0] full;
        bit [31:0] a, b;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NR; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        acc = !rst && !flush && (!m_v || out_ready) && (g >= 0);
        chk({name, ".ready"}, 64'(req_ready), acc ? 64'(1 << g) : 64'd0);
        if (acc) begin
            a = req_a[g*DW +: DW];
            b = req_b[g*DW +: DW];
            full = 33'(a) + 33'(b) + 33'(req_cin[g]);
        end
        @(posedge clk);
        if (rst) begin
            m_v = 0; m_ptr = 0; m_sum = 0; m_cout = 0; m_tag = 0; m_src = 0; m_ovf = 0;
        end else if (flush) begin
            m_v = 0;
        end else if (acc) begin
            m_v = 1; m_sum = full[31:0]; m_cout = full[32];
            m_tag = req_tag[g*TW +: TW]; m_src = g; m_ptr = (g + 1) % NR;
            m_ovf = (a[31] == b[31]) && (full[31] != a[31]);
        end else if (out_ready) begin
            m_v = 0;
        end
        #1;
        chk({name, ".valid"}, 64'(out_valid), 64'(m_v));
        if (m_v) begin
            chk({name, ".sum"},  64'(out_sum),  64'(m_sum));
            chk({name, ".cout"}, 64'(out_cout), 64'(m_cout));
            chk({name, ".tag"},  64'(out_tag),  64'(m_tag));
            chk({name, ".src"},  64'(out_src),  64'(m_src));
`ifdef ADDER_ARB_OVERFLOW_EN
            chk({name, ".ovf"},  64'(out_ovf),  64'(m_ovf));
`endif
        end
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 1;
        req_valid = '1; req_a = '0; req_b = '0; req_cin = '0; req_tag = '0;

        // Reset with all requests valid
        tick("reset");
        chk("reset.sum", 64'(out_sum), 64'd0);
        chk("reset.cout", 64'(out_cout), 64'd0);
        chk("reset.tag", 64'(out_tag), 64'd0);
        chk("reset.src", 64'(out_src), 64'd0);
        rst = 0;

        // First grant to req0: carry out of the wrap
        set_req(0, 32'hFFFF_FFFF, 32'h1, 0, 6'd5);
        set_req(1, 32'h10, 32'h20, 1, 6'd11);
        set_req(2, 32'h8000_0000, 32'h8000_0000, 0, 6'd22);
        set_req(3, 32'h1234_5678, 32'h1111_1111, 1, 6'd33);
        tick("first");
        chk("first.sum", 64'(out_sum), 64'd0);
        chk("first.cout", 64'(out_cout), 64'd1);
        chk("first.src", 64'(out_src), 64'd0);

        // Rotating grants 1,2,3,0 with everyone valid
        for (int i = 0; i < 4; i++) tick("rotate");
        chk("rotate.src", 64'(out_src), 64'd0);

        // Stall: only req1 valid, consumer not ready
        req_valid = 4'b0010; out_ready = 0;
        set_req(1, 32'hDEAD_0000, 32'h0000_BEEF, 0, 6'd17);
        for (int i = 0; i < 3; i++) tick("stall");
        out_ready = 1;
        tick("release");
        chk("release.sum", 64'(out_sum), 64'hDEAD_BEEF);

        // Flush with a held result and req2 waiting
        req_valid = 4'b0100; flush = 1;
        tick("flush");
        flush = 0; req_valid = '1;
        tick("post_flush");
        chk("post_flush.src", 64'(out_src), 64'd2);

`ifdef ADDER_ARB_OVERFLOW_EN
        req_valid = 4'b0001;
        set_req(0, 32'h7FFF_FFFF, 32'h1, 0, 6'd9);
        tick("ovf");
        chk("ovf.flag", 64'(out_ovf), 64'd1);
        chk("ovf.sum", 64'(out_sum), 64'h8000_0000);
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = NR'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 3))
                    0: set_req(i, 32'hFFFF_FFFF, $urandom, 1'($urandom), 6'($urandom));
                    1: set_req(i, 32'h7FFF_FFFF, $urandom_range(0, 2), 1'($urandom), 6'($urandom));
                    default: set_req(i, $urandom, $urandom, 1'($urandom), 6'($urandom));
                endcase
            end
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
